// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-channel shared add/sub scheduler.
//   state_t : scheduler FSM encoding (IDLE / EXEC / DONE)
//   OP_ADD  : op code for a + b
//   OP_SUB  : op code for b - a
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/alu_addsub.sv
// Combinational add/subtract unit shared by both scheduler channels.
//   op     : OP_ADD -> a + b, OP_SUB -> b - a
//   a, b   : WIDTH-bit operands
//   result : low WIDTH bits of the operation
//   flag   : carry-out for add, borrow (a > b) for subtract
module alu_addsub
  import alu_share_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  // One extra bit captures carry on add; on subtract the extended difference
  // wraps negative exactly when a > b, so the top bit is the borrow.
  logic [WIDTH:0] sum;

  always_comb begin
    sum = '0;
    if (op == OP_SUB) sum = {1'b0, b} - {1'b0, a};
    else              sum = {1'b0, a} + {1'b0, b};
  end

  assign result = sum[WIDTH-1:0];
  assign flag   = sum[WIDTH];

endmodule

// File: rtl/alu_share_sched.sv
// Two-channel scheduler sharing a single add/sub unit.
//   clk, rst_n          : clock, async active-low reset
//   reqN, opN, aN, bN   : channel N level request, op code and operands
//   qN, cN              : channel N result and carry/borrow registers
//   doneN               : one-cycle completion pulse for channel N
//   busy                : high whenever the FSM is not IDLE
// A granted request is copied into staging registers in IDLE, computed and
// written back in EXEC, and acknowledged in DONE. Round-robin arbitration
// flips the pointer to the losing channel on every grant.
module alu_share_sched
  import alu_share_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic             c0,
  output logic             c1,
  output logic             done0,
  output logic             done1,
  output logic             busy
);

  localparam int NUM_CH = 2;

  // Channel views as packed arrays so the datapath can index by channel.
  logic [NUM_CH-1:0]            req_v;
  logic [NUM_CH-1:0]            op_v;
  logic [NUM_CH-1:0][WIDTH-1:0] a_v;
  logic [NUM_CH-1:0][WIDTH-1:0] b_v;

  assign req_v = {req1, req0};
  assign op_v  = {op1, op0};
  assign a_v   = {a1, a0};
  assign b_v   = {b1, b0};

  state_t           state, state_nxt;
  logic             rr;        // channel that wins the next contested grant
  logic             gnt_nxt;   // channel chosen this cycle if anyone requests
  logic             gnt_ch;    // channel owning the staged operation
  logic             stg_op;
  logic [WIDTH-1:0] stg_a;
  logic [WIDTH-1:0] stg_b;

  logic [WIDTH-1:0] alu_res;
  logic             alu_flag;

  logic [NUM_CH-1:0]            ld_en;
  logic [NUM_CH-1:0]            done_v;
  logic [NUM_CH-1:0][WIDTH-1:0] q_r;
  logic [NUM_CH-1:0]            c_r;

  // Contested -> pointer decides; otherwise the lone requester (req1 alone
  // selects 1, req0 alone selects 0).
  assign gnt_nxt = (req0 && req1) ? rr : req1;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_en     = '0;
    done_v    = '0;
    case (state)
      IDLE: if (|req_v) state_nxt = EXEC;
      EXEC: begin
        ld_en[gnt_ch] = 1'b1;
        state_nxt     = DONE;
      end
      DONE: begin
        done_v[gnt_ch] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- grant + staging ----------------
  // Operands are captured at grant so later input changes or a dropped
  // request cannot disturb the operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr     <= 1'b0;
      gnt_ch <= 1'b0;
      stg_op <= 1'b0;
      stg_a  <= '0;
      stg_b  <= '0;
    end else if (state == IDLE && (|req_v)) begin
      rr     <= ~gnt_nxt;
      gnt_ch <= gnt_nxt;
      stg_op <= op_v[gnt_nxt];
      stg_a  <= a_v[gnt_nxt];
      stg_b  <= b_v[gnt_nxt];
    end
  end

  alu_addsub #(.WIDTH(WIDTH)) u_alu (
    .op     (stg_op),
    .a      (stg_a),
    .b      (stg_b),
    .result (alu_res),
    .flag   (alu_flag)
  );

  // ---------------- per-channel result registers ----------------
  // Write-enable only: a channel's q/c are untouched unless it owns EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
      c_r <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (ld_en[ch]) begin
          q_r[ch] <= alu_res;
          c_r[ch] <= alu_flag;
        end
      end
    end
  end

  assign q0    = q_r[0];
  assign q1    = q_r[1];
  assign c0    = c_r[0];
  assign c1    = c_r[1];
  assign done0 = done_v[0];
  assign done1 = done_v[1];
  assign busy  = (state != IDLE);

endmodule
